// File: rtl/risc_pkg.sv
// Shared core/memory types: access size encoding, data-responder FSM states,
// and the lane/alignment helpers used by the data memory responder.
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dresp_state_t;

    function automatic logic [3:0] byte_enables(input mem_size_t size, input logic [1:0] off);
        case (size)
            BYTE:      return 4'b0001 << off;
            HALF_WORD: return off[1] ? 4'b1100 : 4'b0011;
            WORD:      return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // The unused size encoding is reported the same way as a misaligned access.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        case (size)
            BYTE:      return 1'b0;
            HALF_WORD: return off[0];
            WORD:      return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised backing store: byte-enabled synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [31:0]                    wdata_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder: one outstanding transfer, fixed RD_LATENCY response,
// alignment / range checking, and sign/zero extension of loads.
module dmem_responder
    import risc_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         dmem_req,
    output logic         dmem_gnt,
    input  logic         dmem_wr_en,
    input  mem_size_t    dmem_size,
    input  logic         dmem_zero_extend,
    input  logic [31:0]  dmem_addr,
    input  logic [31:0]  dmem_wr_data,
    output logic         dmem_rvalid,
    output logic [31:0]  dmem_rd_data,
    output logic         dmem_err,
    output dresp_state_t dbg_state
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [2:0]  LAT_INIT  = 3'(RD_LATENCY - 1);

    dresp_state_t state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;

    logic         wr_en_q;
    mem_size_t    size_q;
    logic         zext_q;
    logic [31:0]  addr_q;
    logic [31:0]  wdata_q;

    logic         accept;
    logic         cur_wr;
    mem_size_t    cur_size;
    logic [31:0]  cur_addr;
    logic [31:0]  cur_wdata;
    logic         cur_err;
    logic [31:0]  lane_wdata;
    logic         commit;

    logic         held_err;
    logic [31:0]  rword;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [31:0]  load_data;

    assign accept    = dmem_req && (state_q == IDLE);
    assign dmem_gnt  = (state_q == IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    if (RD_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q <= 1'b0;
            size_q  <= BYTE;
            zext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            wr_en_q <= dmem_wr_en;
            size_q  <= dmem_size;
            zext_q  <= dmem_zero_extend;
            addr_q  <= dmem_addr;
            wdata_q <= dmem_wr_data;
        end
    end

    // With a single-cycle latency the store commits on the accept edge itself,
    // before the holding registers are loaded, so use the live inputs there.
    always_comb begin
        cur_wr    = wr_en_q;
        cur_size  = size_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_wr    = dmem_wr_en;
            cur_size  = dmem_size;
            cur_addr  = dmem_addr;
            cur_wdata = dmem_wr_data;
        end
    end

    assign cur_err = is_misaligned(cur_size, cur_addr[1:0]) || (cur_addr[31:2] >= DEPTH_LIM);

    always_comb begin
        case (cur_size)
            BYTE:      lane_wdata = {4{cur_wdata[7:0]}};
            HALF_WORD: lane_wdata = {2{cur_wdata[15:0]}};
            default:   lane_wdata = cur_wdata;
        endcase
    end

    assign commit = reset_n && (state_d == RESP) && cur_wr && !cur_err;

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk     (clk),
        .we_i    (commit),
        .be_i    (byte_enables(cur_size, cur_addr[1:0])),
        .waddr_i (cur_addr[AW+1:2]),
        .wdata_i (lane_wdata),
        .raddr_i (addr_q[AW+1:2]),
        .rdata_o (rword)
    );

    assign held_err = is_misaligned(size_q, addr_q[1:0]) || (addr_q[31:2] >= DEPTH_LIM);

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = rword[7:0];
            2'd1:    byte_sel = rword[15:8];
            2'd2:    byte_sel = rword[23:16];
            default: byte_sel = rword[31:24];
        endcase
        half_sel = addr_q[1] ? rword[31:16] : rword[15:0];
        case (size_q)
            BYTE:      load_data = zext_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            HALF_WORD: load_data = zext_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default:   load_data = rword;
        endcase
    end

    assign dmem_rvalid  = (state_q == RESP);
    assign dmem_err     = dmem_rvalid && held_err;
    assign dmem_rd_data = (dmem_rvalid && !wr_en_q && !held_err) ? load_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at RD_LATENCY 1, 3 and 4
// share one clock; each transaction result is compared against hand-computed values.
module tb_dmem_responder;
    import risc_pkg::*;

    logic         clk;
    logic         rst_n   [3];
    logic         req     [3];
    logic         gnt     [3];
    logic         wr_en   [3];
    mem_size_t    size    [3];
    logic         zext    [3];
    logic [31:0]  addr    [3];
    logic [31:0]  wdata   [3];
    logic         rvalid  [3];
    logic [31:0]  rdata   [3];
    logic         err     [3];
    dresp_state_t dbg     [3];

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(rst_n[0]), .dmem_req(req[0]), .dmem_gnt(gnt[0]),
        .dmem_wr_en(wr_en[0]), .dmem_size(size[0]), .dmem_zero_extend(zext[0]),
        .dmem_addr(addr[0]), .dmem_wr_data(wdata[0]), .dmem_rvalid(rvalid[0]),
        .dmem_rd_data(rdata[0]), .dmem_err(err[0]), .dbg_state(dbg[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(3)) u_l3 (
        .clk(clk), .reset_n(rst_n[1]), .dmem_req(req[1]), .dmem_gnt(gnt[1]),
        .dmem_wr_en(wr_en[1]), .dmem_size(size[1]), .dmem_zero_extend(zext[1]),
        .dmem_addr(addr[1]), .dmem_wr_data(wdata[1]), .dmem_rvalid(rvalid[1]),
        .dmem_rd_data(rdata[1]), .dmem_err(err[1]), .dbg_state(dbg[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(4)) u_l4 (
        .clk(clk), .reset_n(rst_n[2]), .dmem_req(req[2]), .dmem_gnt(gnt[2]),
        .dmem_wr_en(wr_en[2]), .dmem_size(size[2]), .dmem_zero_extend(zext[2]),
        .dmem_addr(addr[2]), .dmem_wr_data(wdata[2]), .dmem_rvalid(rvalid[2]),
        .dmem_rd_data(rdata[2]), .dmem_err(err[2]), .dbg_state(dbg[2])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- drivers (called and returning on a negedge) ----------------
    task automatic txn(input int idx, input logic wr, input mem_size_t sz, input logic zx,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic [31:0] post_rd, output logic [31:0] post_flags);
        int n;
        req[idx] = 1'b1; wr_en[idx] = wr; size[idx] = sz; zext[idx] = zx;
        addr[idx] = a; wdata[idx] = wd;
        n = 0;
        while (!gnt[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        // Scramble the inputs after the accept edge; the DUT must use its captured copy.
        req[idx] = 1'b0; wr_en[idx] = ~wr; zext[idx] = ~zx;
        addr[idx] = ~a; wdata[idx] = ~wd;
        lat = 1;
        while (!rvalid[idx] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata[idx];
        er = err[idx];
        @(negedge clk);
        post_rd    = rdata[idx];
        post_flags = {30'd0, rvalid[idx], err[idx]};
    endtask

    task automatic run_vec(input string tag, input int idx, input logic wr, input mem_size_t sz,
                           input logic zx, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd, post_rd, post_flags;
        logic        er;
        int          lat;
        txn(idx, wr, sz, zx, a, wd, rd, er, lat, post_rd, post_flags);
        check({tag, " lat"}, lat, exp_lat);
        check({tag, " rd"}, rd, exp_rd);
        check({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, " idle_rd"}, post_rd, 32'd0);
        check({tag, " idle_flags"}, post_flags, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; wr_en[i] = 1'b0; size[i] = BYTE;
            zext[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d gnt", i), {31'd0, gnt[i]}, 32'd1);
            check($sformatf("reset%0d rvalid", i), {31'd0, rvalid[i]}, 32'd0);
            check($sformatf("reset%0d rd", i), rdata[i], 32'd0);
            check($sformatf("reset%0d err", i), {31'd0, err[i]}, 32'd0);
            check($sformatf("reset%0d state", i), {30'd0, dbg[i]}, {30'd0, IDLE});
            rst_n[i] = 1'b1;
        end
        @(negedge clk);

        // RD_LATENCY = 1: data path, extension, lane masking, errors
        run_vec("st_w 10",    0, 1, WORD,      0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 1);
        run_vec("ld_w 10",    0, 0, WORD,      0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 1);
        run_vec("ld_b 13 s",  0, 0, BYTE,      0, 32'h13,       32'h0,        32'hFFFFFFDE, 0, 1);
        run_vec("ld_b 13 z",  0, 0, BYTE,      1, 32'h13,       32'h0,        32'h000000DE, 0, 1);
        run_vec("ld_h 10 s",  0, 0, HALF_WORD, 0, 32'h10,       32'h0,        32'hFFFFBEEF, 0, 1);
        run_vec("ld_h 12 z",  0, 0, HALF_WORD, 1, 32'h12,       32'h0,        32'h0000DEAD, 0, 1);
        run_vec("st_b 11",    0, 1, BYTE,      0, 32'h11,       32'hAAAAAA55, 32'h0,        0, 1);
        run_vec("ld_w 10 b",  0, 0, WORD,      0, 32'h10,       32'h0,        32'hDEAD55EF, 0, 1);
        run_vec("ld_b 11 s",  0, 0, BYTE,      0, 32'h11,       32'h0,        32'h00000055, 0, 1);
        run_vec("st_w 14",    0, 1, WORD,      0, 32'h14,       32'h00000000, 32'h0,        0, 1);
        run_vec("st_h 16",    0, 1, HALF_WORD, 0, 32'h16,       32'hFFFF8001, 32'h0,        0, 1);
        run_vec("ld_w 14",    0, 0, WORD,      0, 32'h14,       32'h0,        32'h80010000, 0, 1);
        run_vec("ld_h 16 s",  0, 0, HALF_WORD, 0, 32'h16,       32'h0,        32'hFFFF8001, 0, 1);
        run_vec("ld_w 12 ma", 0, 0, WORD,      0, 32'h12,       32'h0,        32'h0,        1, 1);
        run_vec("ld_h 11 ma", 0, 0, HALF_WORD, 0, 32'h11,       32'h0,        32'h0,        1, 1);
        run_vec("st_w 0",     0, 1, WORD,      0, 32'h0,        32'h0BADF00D, 32'h0,        0, 1);
        run_vec("st_w oor",   0, 1, WORD,      0, 32'h1000,     32'hFFFFFFFF, 32'h0,        1, 1);
        run_vec("ld_w 0 chk", 0, 0, WORD,      0, 32'h0,        32'h0,        32'h0BADF00D, 0, 1);
        run_vec("ld_w 10 ck", 0, 0, WORD,      0, 32'h10,       32'h0,        32'hDEAD55EF, 0, 1);
        run_vec("st_w 11 ma", 0, 1, WORD,      0, 32'h11,       32'h12345678, 32'h0,        1, 1);
        run_vec("ld_w 10 c2", 0, 0, WORD,      0, 32'h10,       32'h0,        32'hDEAD55EF, 0, 1);
        run_vec("ld_w hi oor",0, 0, WORD,      0, 32'hFFFFFFFC, 32'h0,        32'h0,        1, 1);

        // RD_LATENCY = 3: latency and back-to-back with req held high
        run_vec("l3 st 10",   1, 1, WORD,      0, 32'h10,       32'hCAFEF00D, 32'h0,        0, 3);
        run_vec("l3 st 14",   1, 1, WORD,      0, 32'h14,       32'h12345678, 32'h0,        0, 3);
        req[1] = 1'b1; wr_en[1] = 1'b0; size[1] = WORD; zext[1] = 1'b0; addr[1] = 32'h10;
        check("b2b c0 gnt", {31'd0, gnt[1]}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) addr[1] = 32'h14;
            check($sformatf("b2b c%0d gnt", k), {31'd0, gnt[1]},
                  {31'd0, !((k >= 1 && k <= 3) || (k >= 5 && k <= 7))});
            check($sformatf("b2b c%0d rvalid", k), {31'd0, rvalid[1]}, {31'd0, (k == 3 || k == 7)});
            if (k == 3) check("b2b first rd", rdata[1], 32'hCAFEF00D);
            if (k == 7) check("b2b second rd", rdata[1], 32'h12345678);
            if (k == 5) req[1] = 1'b0;
        end

        // RD_LATENCY = 4: reset two cycles after a store accept drops it
        run_vec("l4 st 20",   2, 1, WORD,      0, 32'h20,       32'h11111111, 32'h0,        0, 4);
        req[2] = 1'b1; wr_en[2] = 1'b1; size[2] = WORD; addr[2] = 32'h20; wdata[2] = 32'hBADBADBA;
        @(negedge clk);
        req[2] = 1'b0;
        check("rst busy gnt", {31'd0, gnt[2]}, 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        check("rst state", {30'd0, dbg[2]}, {30'd0, IDLE});
        check("rst rvalid", {31'd0, rvalid[2]}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("post-rst c%0d rvalid", k), {31'd0, rvalid[2]}, 32'd0);
            check($sformatf("post-rst c%0d gnt", k), {31'd0, gnt[2]}, 32'd1);
        end
        run_vec("l4 ld 20",   2, 0, WORD,      0, 32'h20,       32'h0,        32'h11111111, 0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array (power of two, 16..65536).
REQ-002 SHALL have parameter RD_LATENCY, default 1, cycles from accept edge to response (legal 1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port dmem_req, input, 1, the core requests a transfer.
REQ-006 SHALL have port dmem_gnt, output, 1, the request is accepted on this edge when dmem_req is also high.
REQ-007 SHALL have port dmem_wr_en, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port dmem_size, input, mem_size_t, BYTE / HALF_WORD / WORD.
REQ-009 SHALL have port dmem_zero_extend, input, 1, 1 = zero-extend the load, 0 = sign-extend it.
REQ-010 SHALL have port dmem_addr, input, 32, byte address.
REQ-011 SHALL have port dmem_wr_data, input, 32, store data, right-aligned (bits [7:0] for BYTE).
REQ-012 SHALL have port dmem_rvalid, output, 1, one-cycle pulse that completes a transaction.
REQ-013 SHALL have port dmem_rd_data, output, 32, extended load data, valid only while dmem_rvalid is high.
REQ-014 SHALL have port dmem_err, output, 1, error flag, qualified by dmem_rvalid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; dmem_gnt = (state==IDLE).
REQ-016 SHALL accept a request on the edge where dmem_req & dmem_gnt is high, capturing wr_en, size, zero_extend, addr and wr_data into holding registers; core inputs are ignored afterwards.
REQ-017 SHALL go from IDLE on accept to RESP if RD_LATENCY==1, otherwise to WAIT with a down-counter loaded with RD_LATENCY-1.
REQ-018 SHALL move from WAIT to RESP when the counter reaches 1; WAIT decrements the counter each cycle.
REQ-019 SHALL drive dmem_rvalid=1 only in RESP, then return to IDLE; dmem_rvalid is therefore high exactly RD_LATENCY cycles after the accept edge.
REQ-020 SHALL sustain a maximum throughput of one transaction per RD_LATENCY+1 cycles; dmem_req held high across RESP is accepted on the next IDLE cycle.
REQ-021 SHALL flag misalignment: HALF_WORD with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-022 SHALL flag out-of-range: addr[31:2] >= DEPTH_WORDS.
REQ-023 SHALL, on a misaligned or out-of-range access, not modify the array, drive dmem_err=1 and dmem_rd_data=0 in RESP, with timing unchanged.
REQ-024 SHALL commit a store to the array on the edge entering RESP, using byte enables from size and addr[1:0]: BYTE one lane, HALF_WORD lanes {1:0} or {3:2}, WORD all four.
REQ-025 SHALL, for a store, drive dmem_rd_data=0 and dmem_err=0 in RESP.
REQ-026 SHALL, for a load, select the addressed byte or halfword and extend it per zero_extend to 32 bits; WORD loads return the word unchanged.
REQ-027 SHALL hold dmem_rd_data=0 and dmem_err=0 whenever dmem_rvalid=0.
REQ-028 SHALL return post-write data when a load follows a store to the same word (stores commit before the load's RESP).

Reset
REQ-029 SHALL, on reset_n low, immediately force state=IDLE, counter=0, dmem_rvalid=0, dmem_err=0, dmem_rd_data=0 and dmem_gnt=1 (once released).
REQ-030 SHALL, on reset mid-transaction, drop the transaction with no response; an uncommitted store is lost and array contents are otherwise preserved (the array is not reset).

Structure
REQ-031 SHALL take mem_size_t from the shared risc_pkg and add dresp_state_t (IDLE/WAIT/RESP) to it.
REQ-032 SHALL place the backing array in one sub-module, dmem_bank, with a byte-enabled synchronous write and a combinational read.

Verification
REQ-033 SHALL verify a WORD store: RD_LATENCY=1, store 0xDEADBEEF @0x10 -> rvalid exactly 1 cycle after accept, err=0; a WORD load @0x10 then returns 0xDEADBEEF.
REQ-034 SHALL verify byte load extension: after the above, a BYTE load @0x13 with zero_extend=0 -> 0xFFFFFFDE; with zero_extend=1 -> 0x000000DE; a HALF_WORD load @0x10 with zero_extend=0 -> 0xFFFFBEEF.
REQ-035 SHALL verify lane masking: a BYTE store 0x55 @0x11 over 0xDEADBEEF -> a WORD load @0x10 returns 0xDEAD55EF.
REQ-036 SHALL verify errors: a WORD load @0x12 -> rvalid, err=1, rd_data=0; a store @ DEPTH_WORDS*4 -> err=1 and no word in the array changes.
REQ-037 SHALL verify latency and back-to-back: RD_LATENCY=3 with dmem_req held high for 2 loads -> gnt low for 3 cycles after each accept, rvalid on cycles +3 and +7.
REQ-038 SHALL verify reset mid-operation: RD_LATENCY=4, assert reset_n low 2 cycles after a store accept -> no rvalid, target word unchanged, gnt=1 after release.
